// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin request/grant interface.
// Used by rr_requester and by the arbiter's test environment.
package rr_pkg;

  localparam int RR_CLIENTS     = 32;
  localparam int RR_MAX_CLIENTS = 256;
  localparam int RR_MAX_IDW     = 8;

  typedef struct packed {
    logic overflow;
    logic protocol;
  } rr_err_t;

  // OR of the indices of all set bits; exact for one-hot input, zero for zero input.
  function automatic logic [RR_MAX_IDW-1:0] onehot_to_bin(input logic [RR_MAX_CLIENTS-1:0] i_vec);
    logic [RR_MAX_IDW-1:0] idx;
    idx = '0;
    for (int i = 0; i < RR_MAX_CLIENTS; i++) begin
      if (i_vec[i]) begin
        idx = idx | RR_MAX_IDW'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_client_counter.sv
// Saturating outstanding-request counter for one client; request and
// enq_ready are decoded from the registered count only.
module rr_client_counter #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_enq,
  input  logic i_grant,
  output logic o_enq_ready,
  output logic o_request,
  output logic o_overflow
);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          w_full;
  logic          w_empty;
  logic          w_inc;
  logic          w_dec;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_inc   = i_enq & ~w_full;
  assign w_dec   = i_grant & ~w_empty;

  // Simultaneous inc and dec cancel, so request never glitches low.
  always_comb begin
    w_count_nxt = r_count;
    if (w_inc && !w_dec) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_inc && w_dec) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign o_enq_ready = ~w_full;
  assign o_request   = ~w_empty;
  assign o_overflow  = i_enq & w_full;

endmodule

// File: rtl/rr_requester.sv
// Client-side front end for rr_arbiter: per-client request counters, grant
// legality checking, registered binary grant stream and sticky error flags.
module rr_requester
  import rr_pkg::*;
#(
  parameter int CLIENTS = RR_CLIENTS,
  parameter int DEPTH   = 4,
  parameter int IDW     = $clog2(CLIENTS),
  parameter int CW      = $clog2(DEPTH + 1)
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic [CLIENTS-1:0] i_enq,
  output logic [CLIENTS-1:0] o_enq_ready,
  output logic [CLIENTS-1:0] o_request,
  input  logic [CLIENTS-1:0] i_grant,
  output logic               o_stall,
  input  logic               i_sink_ready,
  output logic               o_grant_valid,
  output logic [IDW-1:0]     o_grant_id,
  output logic               o_overflow_err,
  output logic               o_protocol_err
);

  logic [CLIENTS-1:0]        w_request;
  logic [CLIENTS-1:0]        w_enq_ready;
  logic [CLIENTS-1:0]        w_overflow;
  logic [CLIENTS-1:0]        w_grant_eff;
  logic [RR_MAX_CLIENTS-1:0] w_grant_wide;
  logic                      w_grant_any;
  logic                      w_not_onehot;
  logic                      w_unrequested;
  logic                      w_stalled_grant;
  logic                      w_illegal;
  logic                      w_grant_ok;

  logic                      r_grant_valid;
  logic [IDW-1:0]            r_grant_id;
  rr_err_t                   r_err;

  assign o_stall = ~i_sink_ready;

  // An illegal grant is ignored entirely: no decrement, no grant_valid.
  assign w_grant_any     = |i_grant;
  assign w_not_onehot    = |(i_grant & (i_grant - CLIENTS'(1)));
  assign w_unrequested   = |(i_grant & ~w_request);
  assign w_stalled_grant = w_grant_any & ~i_sink_ready;
  assign w_illegal       = w_grant_any & (w_not_onehot | w_unrequested | w_stalled_grant);
  assign w_grant_ok      = w_grant_any & ~w_illegal;
  assign w_grant_eff     = w_grant_ok ? i_grant : '0;

  always_comb begin
    w_grant_wide              = '0;
    w_grant_wide[CLIENTS-1:0] = i_grant;
  end

  for (genvar g = 0; g < CLIENTS; g++) begin : g_client
    rr_client_counter #(
      .DEPTH (DEPTH),
      .CW    (CW)
    ) u_counter (
      .i_clock     (i_clock),
      .i_reset_n   (i_reset_n),
      .i_enq       (i_enq[g]),
      .i_grant     (w_grant_eff[g]),
      .o_enq_ready (w_enq_ready[g]),
      .o_request   (w_request[g]),
      .o_overflow  (w_overflow[g])
    );
  end

  // grant_id holds its last value whenever no legal grant is consumed.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_err         <= '0;
    end else begin
      r_grant_valid <= w_grant_ok;
      if (w_grant_ok) begin
        r_grant_id <= IDW'(onehot_to_bin(w_grant_wide));
      end
      r_err.overflow <= r_err.overflow | (|w_overflow);
      r_err.protocol <= r_err.protocol | w_illegal;
    end
  end

  assign o_request      = w_request;
  assign o_enq_ready    = w_enq_ready;
  assign o_grant_valid  = r_grant_valid;
  assign o_grant_id     = r_grant_id;
  assign o_overflow_err = r_err.overflow;
  assign o_protocol_err = r_err.protocol;

endmodule

// File: tb/tb_rr_requester.sv
// Self-checking bench for rr_requester: per-client count model plus
// directed scenarios with literal expectations.
module tb_rr_requester;
  import rr_pkg::*;

  localparam int CLIENTS = 32;
  localparam int DEPTH   = 4;
  localparam int IDW     = 5;

  logic               clock = 1'b0;
  logic               resetN = 1'b0;
  logic [CLIENTS-1:0] enq = '0;
  logic [CLIENTS-1:0] grant = '0;
  logic               sinkReady = 1'b1;
  logic [CLIENTS-1:0] enqReady;
  logic [CLIENTS-1:0] request;
  logic               stall;
  logic               grantValid;
  logic [IDW-1:0]     grantId;
  logic               overflowErr;
  logic               protocolErr;

  int checks = 0;
  int failures = 0;

  int mCnt [CLIENTS];
  bit mOvf = 0;
  bit mPerr = 0;
  bit mGv = 0;
  int mGid = 0;

  always #5 clock = ~clock;

  rr_requester #(
    .CLIENTS (CLIENTS),
    .DEPTH   (DEPTH)
  ) dut (
    .i_clock        (clock),
    .i_reset_n      (resetN),
    .i_enq          (enq),
    .o_enq_ready    (enqReady),
    .o_request      (request),
    .i_grant        (grant),
    .o_stall        (stall),
    .i_sink_ready   (sinkReady),
    .o_grant_valid  (grantValid),
    .o_grant_id     (grantId),
    .o_overflow_err (overflowErr),
    .o_protocol_err (protocolErr)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelClear();
    for (int i = 0; i < CLIENTS; i++) mCnt[i] = 0;
    mOvf = 0;
    mPerr = 0;
    mGv = 0;
    mGid = 0;
  endfunction

  // One clock edge of the client-count model.
  function automatic void modelStep();
    bit bad;
    bad = 0;
    if (grant != '0) begin
      if ($countones(grant) != 1) bad = 1;
      if (!sinkReady) bad = 1;
      for (int i = 0; i < CLIENTS; i++)
        if (grant[i] && mCnt[i] == 0) bad = 1;
    end
    if (bad) mPerr = 1;
    mGv = (grant != '0) && !bad;
    for (int i = 0; i < CLIENTS; i++) begin
      if (mGv && grant[i]) mGid = i;
      if (enq[i]) begin
        if (mCnt[i] == DEPTH) mOvf = 1;
        else mCnt[i] = mCnt[i] + 1;
      end
      if (mGv && grant[i]) mCnt[i] = mCnt[i] - 1;
    end
  endfunction

  initial modelClear();
  always @(negedge resetN) modelClear();
  always @(posedge clock) if (resetN) modelStep();

  always @(negedge clock) begin
    logic [CLIENTS-1:0] expReq;
    logic [CLIENTS-1:0] expRdy;
    for (int i = 0; i < CLIENTS; i++) begin
      expReq[i] = (mCnt[i] != 0);
      expRdy[i] = (mCnt[i] < DEPTH);
    end
    checkOutput("model_request", request, expReq);
    checkOutput("model_enq_ready", enqReady, expRdy);
    checkOutput("model_grant_valid", 32'(grantValid), 32'(mGv));
    checkOutput("model_grant_id", 32'(grantId), 32'(mGid));
    checkOutput("model_overflow_err", 32'(overflowErr), 32'(mOvf));
    checkOutput("model_protocol_err", 32'(protocolErr), 32'(mPerr));
    checkOutput("model_stall", 32'(stall), 32'(!sinkReady));
  end

  // One clock edge with the given inputs; returns just after the edge with enq/grant idle.
  task automatic applyStimulus(input logic [CLIENTS-1:0] e, input logic [CLIENTS-1:0] g, input logic s);
    enq = e;
    grant = g;
    sinkReady = s;
    @(posedge clock);
    #1;
    enq = '0;
    grant = '0;
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
    #1;
    checkOutput("reset_request", request, 32'h0);
    checkOutput("reset_enq_ready", enqReady, 32'hFFFF_FFFF);
    checkOutput("reset_grant_valid", 32'(grantValid), 32'h0);
    checkOutput("reset_grant_id", 32'(grantId), 32'h0);
    checkOutput("reset_errors", {30'h0, overflowErr, protocolErr}, 32'h0);

    applyStimulus(32'h8, 32'h0, 1'b1);
    checkOutput("enq3_request", request, 32'h8);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(32'h0, 32'h0, 1'b1);
      checkOutput("enq3_hold", request, 32'h8);
    end
    applyStimulus(32'h0, 32'h8, 1'b1);
    checkOutput("grant3_valid", 32'(grantValid), 32'h1);
    checkOutput("grant3_id", 32'(grantId), 32'd3);
    checkOutput("grant3_request", request, 32'h0);

    applyStimulus(32'h20, 32'h0, 1'b1);
    applyStimulus(32'h20, 32'h0, 1'b1);
    applyStimulus(32'h0, 32'h20, 1'b1);
    checkOutput("c5_g1_valid", 32'(grantValid), 32'h1);
    checkOutput("c5_g1_id", 32'(grantId), 32'd5);
    checkOutput("c5_g1_request", request, 32'h20);
    applyStimulus(32'h0, 32'h20, 1'b1);
    checkOutput("c5_g2_valid", 32'(grantValid), 32'h1);
    checkOutput("c5_g2_id", 32'(grantId), 32'd5);
    checkOutput("c5_g2_request", request, 32'h0);
    applyStimulus(32'h0, 32'h0, 1'b1);
    checkOutput("c5_idle_valid", 32'(grantValid), 32'h0);
    checkOutput("c5_idle_id_hold", 32'(grantId), 32'd5);

    for (int i = 1; i <= 5; i++) begin
      applyStimulus(32'h1, 32'h0, 1'b1);
      if (i == 4) begin
        checkOutput("ovf_ready_low", 32'(enqReady[0]), 32'h0);
        checkOutput("ovf_not_yet", 32'(overflowErr), 32'h0);
      end
    end
    checkOutput("ovf_set", 32'(overflowErr), 32'h1);
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(32'h0, 32'h1, 1'b1);
      checkOutput("drain_valid", 32'(grantValid), 32'h1);
      checkOutput("drain_request0", 32'(request[0]), (i < DEPTH) ? 32'h1 : 32'h0);
    end

    applyStimulus(32'h80, 32'h0, 1'b1);
    applyStimulus(32'h80, 32'h80, 1'b1);
    checkOutput("c7_same_request", 32'(request[7]), 32'h1);
    checkOutput("c7_same_valid", 32'(grantValid), 32'h1);
    checkOutput("c7_same_id", 32'(grantId), 32'd7);
    applyStimulus(32'h0, 32'h80, 1'b1);
    checkOutput("c7_count_one", 32'(request[7]), 32'h0);

    applyStimulus(32'h1, 32'h0, 1'b1);
    sinkReady = 1'b0;
    #1;
    checkOutput("stall_comb", 32'(stall), 32'h1);
    applyStimulus(32'h0, 32'h1, 1'b0);
    checkOutput("stall_perr", 32'(protocolErr), 32'h1);
    checkOutput("stall_no_valid", 32'(grantValid), 32'h0);
    checkOutput("stall_no_dec", 32'(request[0]), 32'h1);
    sinkReady = 1'b1;

    for (int i = 0; i < 3; i++) applyStimulus(32'h4, 32'h0, 1'b1);
    checkOutput("c2_request", request, 32'h5);
    #3;
    resetN = 1'b0;
    #1;
    checkOutput("rst_mid_request", request, 32'h0);
    checkOutput("rst_mid_ready", enqReady, 32'hFFFF_FFFF);
    checkOutput("rst_mid_errors", {30'h0, overflowErr, protocolErr}, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
    applyStimulus(32'h0, 32'h0, 1'b1);
    checkOutput("rst_after_request", request, 32'h0);
    checkOutput("rst_after_ready", enqReady, 32'hFFFF_FFFF);
    checkOutput("rst_after_valid", 32'(grantValid), 32'h0);

    applyStimulus(32'h3, 32'h0, 1'b1);
    applyStimulus(32'h0, 32'h3, 1'b1);
    checkOutput("multi_perr", 32'(protocolErr), 32'h1);
    checkOutput("multi_no_valid", 32'(grantValid), 32'h0);
    checkOutput("multi_no_dec", request, 32'h3);
    applyStimulus(32'h0, 32'h2, 1'b1);
    checkOutput("legal_after_valid", 32'(grantValid), 32'h1);
    checkOutput("legal_after_id", 32'(grantId), 32'd1);
    checkOutput("legal_after_request", request, 32'h1);

    repeat (2) @(posedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
